// File: rtl/vending_machine_change.sv
// Vending-machine controller: collects 5/10/25-cent coins as nickel credit and
// dispenses at PRICE_CENTS. Overpayment is returned as nickel pulses or carried forward.
module vending_machine_change #(
  parameter int PRICE_CENTS = 25,
  parameter bit CHANGE_EN   = 1'b1,
  localparam int PRICE_N    = PRICE_CENTS / 5,
  localparam int CREDIT_W   = $clog2(PRICE_N + 5)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fiveCents,
  input  logic                tenCents,
  input  logic                twentyFiveCents,
  input  logic                cancel,
  output logic                theProduct,
  output logic                changeNickel,
  output logic                coinReject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W:0]   LP_PRICE_X = (CREDIT_W+1)'(PRICE_N);
  localparam logic [CREDIT_W-1:0] LP_PRICE   = CREDIT_W'(PRICE_N);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;

  logic [1:0]          w_ncoins;
  logic                w_any;
  logic                w_single;
  logic [2:0]          w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_full;
  logic                w_accept;
  logic [CREDIT_W-1:0] w_rem;

  assign w_ncoins = {1'b0, fiveCents} + {1'b0, tenCents} + {1'b0, twentyFiveCents};
  assign w_any    = fiveCents | tenCents | twentyFiveCents;
  assign w_single = (w_ncoins == 2'd1);

  always_comb begin
    w_coin_val = 3'd0;
    if (fiveCents)            w_coin_val = 3'd1;
    else if (tenCents)        w_coin_val = 3'd2;
    else if (twentyFiveCents) w_coin_val = 3'd5;
  end

  assign w_sum  = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
  // A carried remainder can already cover the price when PRICE_N < 5; coins wait until it is spent.
  assign w_full = (r_credit >= LP_PRICE);
  assign w_rem  = r_credit - LP_PRICE;

  assign w_accept   = (r_state == COLLECT) && !cancel && !w_full && w_single;
  assign coinReject = w_any && !w_accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= COLLECT;
      r_credit <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_full) begin
            r_state <= VEND;
          end else if (cancel) begin
            if (r_credit != '0) r_state <= CHANGE;
          end else if (w_single) begin
            r_credit <= w_sum[CREDIT_W-1:0];
            if (w_sum >= LP_PRICE_X) r_state <= VEND;
          end
        end
        VEND: begin
          r_credit <= w_rem;
          r_state  <= (CHANGE_EN && (w_rem != '0)) ? CHANGE : COLLECT;
        end
        CHANGE: begin
          if (r_credit <= CREDIT_W'(1)) begin
            r_credit <= '0;
            r_state  <= COLLECT;
          end else begin
            r_credit <= r_credit - CREDIT_W'(1);
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign theProduct   = (r_state == VEND);
  assign changeNickel = (r_state == CHANGE);
  assign busy         = (r_state != COLLECT);
  assign credit       = r_credit;

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed bench for vending_machine_change: one change-returning and one
// credit-carrying instance, checked against a cycle-tagged scoreboard.
module tb_vending_machine_change;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic [1:0] fv = '0, tv = '0, qv = '0, cv = '0;
  logic [1:0] prod, nick, rej, busy;
  logic [3:0] cr1, cr0;

  vending_machine_change #(.PRICE_CENTS(25), .CHANGE_EN(1'b1)) dut1 (
    .clock(clock), .reset(reset), .fiveCents(fv[1]), .tenCents(tv[1]),
    .twentyFiveCents(qv[1]), .cancel(cv[1]), .theProduct(prod[1]),
    .changeNickel(nick[1]), .coinReject(rej[1]), .credit(cr1), .busy(busy[1]));

  vending_machine_change #(.PRICE_CENTS(25), .CHANGE_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .fiveCents(fv[0]), .tenCents(tv[0]),
    .twentyFiveCents(qv[0]), .cancel(cv[0]), .theProduct(prod[0]),
    .changeNickel(nick[0]), .coinReject(rej[0]), .credit(cr0), .busy(busy[0]));

  typedef struct {
    int         cyc;
    int         sel;
    int         id;
    logic [6:0] outs;  // {credit, theProduct, changeNickel, busy}
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Pop every expectation that targets the current cycle and compare registered outputs.
  always @(negedge clock) begin : mon
    exp_t       e;
    logic [6:0] obs;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e   = sb.pop_front();
      obs = (e.sel == 1) ? {cr1, prod[1], nick[1], busy[1]}
                         : {cr0, prod[0], nick[0], busy[0]};
      tests++;
      assert (obs === e.outs) else begin
        fails++;
        $error("FAIL step%0d outs {credit,prod,nick,busy} observed=%0d,%b expected=%0d,%b",
               e.id, obs[6:3], obs[2:0], e.outs[6:3], e.outs[2:0]);
      end
    end
  end

  // Drive one cycle of stimulus, check coinReject combinationally, queue post-edge expectation.
  task automatic step(input int id, input int sel, input bit rs,
                      input bit fi, input bit te, input bit qu, input bit ca,
                      input bit erej, input logic [3:0] ecr,
                      input bit ep, input bit en, input bit eb);
    exp_t e;
    @(posedge clock); #1;
    reset = rs;
    fv = '0; tv = '0; qv = '0; cv = '0;
    fv[sel] = fi; tv[sel] = te; qv[sel] = qu; cv[sel] = ca;
    #1;
    tests++;
    assert (rej[sel] === erej) else begin
      fails++;
      $error("FAIL step%0d coinReject observed=%0b expected=%0b", id, rej[sel], erej);
    end
    e.cyc  = cyc_cnt + 1;
    e.sel  = sel;
    e.id   = id;
    e.outs = {ecr, ep, en, eb};
    sb.push_back(e);
  endtask

  initial begin
    //   id sel rs  f t q c  rej cr  p n b
    step( 1, 1, 1, 0,0,0,0,  0, 0, 0,0,0);
    step( 2, 0, 1, 0,0,0,0,  0, 0, 0,0,0);
    // 10,5,5,10 -> sale with one nickel of change
    step( 3, 1, 0, 0,1,0,0,  0, 2, 0,0,0);
    step( 4, 1, 0, 1,0,0,0,  0, 3, 0,0,0);
    step( 5, 1, 0, 1,0,0,0,  0, 4, 0,0,0);
    step( 6, 1, 0, 0,1,0,0,  0, 6, 1,0,1);
    step( 7, 1, 0, 0,0,0,0,  0, 1, 0,1,1);
    step( 8, 1, 0, 0,0,0,0,  0, 0, 0,0,0);
    // exact quarter; a nickel during VEND is rejected
    step( 9, 1, 0, 0,0,1,0,  0, 5, 1,0,1);
    step(10, 1, 0, 1,0,0,0,  1, 0, 0,0,0);
    // 10,10, cancel -> 4-nickel refund; quarter during CHANGE rejected
    step(11, 1, 0, 0,1,0,0,  0, 2, 0,0,0);
    step(12, 1, 0, 0,1,0,0,  0, 4, 0,0,0);
    step(13, 1, 0, 0,0,0,1,  0, 4, 0,1,1);
    step(14, 1, 0, 0,0,0,0,  0, 3, 0,1,1);
    step(15, 1, 0, 0,0,1,0,  1, 2, 0,1,1);
    step(16, 1, 0, 0,0,0,0,  0, 1, 0,1,1);
    step(17, 1, 0, 0,0,0,0,  0, 0, 0,0,0);
    // simultaneous coins rejected; coin with cancel rejected; cancel at zero is a no-op
    step(18, 1, 0, 1,0,0,0,  0, 1, 0,0,0);
    step(19, 1, 0, 1,1,0,0,  1, 1, 0,0,0);
    step(20, 1, 0, 0,1,0,1,  1, 1, 0,1,1);
    step(21, 1, 0, 0,0,0,0,  0, 0, 0,0,0);
    step(22, 1, 0, 0,0,0,1,  0, 0, 0,0,0);
    // reset during the first refund pulse forfeits the rest
    step(23, 1, 0, 0,1,0,0,  0, 2, 0,0,0);
    step(24, 1, 0, 0,1,0,0,  0, 4, 0,0,0);
    step(25, 1, 0, 0,0,0,1,  0, 4, 0,1,1);
    step(26, 1, 1, 0,0,0,0,  0, 0, 0,0,0);
    step(27, 1, 0, 0,0,0,0,  0, 0, 0,0,0);
    // carry-forward instance: 25, 5, 25 -> remainder 1 stays as credit
    step(28, 0, 0, 0,0,1,0,  0, 5, 1,0,1);
    step(29, 0, 0, 0,0,0,0,  0, 0, 0,0,0);
    step(30, 0, 0, 1,0,0,0,  0, 1, 0,0,0);
    step(31, 0, 0, 0,0,1,0,  0, 6, 1,0,1);
    step(32, 0, 0, 0,0,0,0,  0, 1, 0,0,0);
    step(33, 0, 0, 0,0,0,0,  0, 1, 0,0,0);
    step(34, 0, 0, 0,0,0,1,  0, 1, 0,1,1);
    step(35, 0, 0, 0,0,0,0,  0, 0, 0,0,0);
    @(posedge clock); #1;
    fv = '0; tv = '0; qv = '0; cv = '0;
    repeat (3) @(negedge clock);
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain scoreboard observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
